// File: rtl/byte_lane_data_memory_if.sv
// Request/response bundle for byte_lane_data_memory: single-outstanding valid/ready request
// channel from the MEM stage and a valid/ready response channel back to it.
interface byte_lane_data_memory_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/byte_lane_data_memory.sv
// Little-endian byte-lane data memory (byte/half/word, load extension, error detection) with a
// programmable access latency. Define DMEM_CLEAR_ON_RESET_EN to also zero the storage on rst.
module byte_lane_data_memory #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    byte_lane_data_memory_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int AW1   = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [7:0]            mem [DEPTH_BYTES];
    logic                  commit;
    logic                  acc_err;
    logic [3:0]            lane_en;
    logic [AW1-1:0]        nbytes;
    logic [AW1-1:0]        end_addr;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] raw;

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [1:0] size, input logic uns,
                                                          input logic [DATA_WIDTH-1:0] raw_word);
        logic [DATA_WIDTH-1:0] ext;
        case (size)
            2'b00:   ext = {{24{raw_word[7] & ~uns}}, raw_word[7:0]};
            2'b01:   ext = {{16{raw_word[15] & ~uns}}, raw_word[15:0]};
            default: ext = raw_word;
        endcase
        return ext;
    endfunction

    // Decode of the latched request; the end-address sum is one bit wider so it cannot wrap.
    always_comb begin
        lane_en = 4'b1111;
        nbytes  = AW1'(4);
        raw     = '0;
        case (size_q)
            2'b00: begin lane_en = 4'b0001; nbytes = AW1'(1); end
            2'b01: begin lane_en = 4'b0011; nbytes = AW1'(2); end
            default: ;
        endcase
        end_addr = {1'b0, addr_q} + nbytes;
        acc_err  = (size_q == 2'b11)
                || (size_q == 2'b01 && addr_q[0])
                || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
                || (end_addr > AW1'(DEPTH_BYTES));
        idx = addr_q[IDX_W-1:0];
        for (int n = 0; n < 4; n++) begin
            raw[8*n +: 8] = mem[idx + IDX_W'(n)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_ACCESS;
                    cnt_d   = 3'(READ_LATENCY - 1);
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || write_q) ? '0 : extend_load(size_q, uns_q, raw);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A reset landing on the commit edge wins, so an in-flight store is never written.
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (rst) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[IDX_W'(i)] <= 8'h00;
        end else
`endif
        if (!rst && commit && write_q && !acc_err) begin
            for (int n = 0; n < 4; n++) begin
                if (lane_en[n]) mem[idx + IDX_W'(n)] <= wdata_q[8*n +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Bench for byte_lane_data_memory: two instances (latency 1 and 4) driven from shared stimulus,
// checked every cycle against a timestamp/array reference model plus literal expectations.
module tb_byte_lane_data_memory;
    localparam int DEPTH = 4096;
    localparam int LAT0  = 1;
    localparam int LAT1  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel          = 0;
    logic        req_valid    = 1'b0;
    logic        req_write    = 1'b0;
    logic [1:0]  req_size     = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr     = '0;
    logic [31:0] req_wdata    = '0;
    logic        rsp_ready    = 1'b0;

    byte_lane_data_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    byte_lane_data_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.req_valid    = req_valid && (sel == 0);
    assign bus0.rsp_ready    = rsp_ready && (sel == 0);
    assign bus0.req_write    = req_write;
    assign bus0.req_size     = req_size;
    assign bus0.req_unsigned = req_unsigned;
    assign bus0.req_addr     = req_addr;
    assign bus0.req_wdata    = req_wdata;
    assign bus1.req_valid    = req_valid && (sel == 1);
    assign bus1.rsp_ready    = rsp_ready && (sel == 1);
    assign bus1.req_write    = req_write;
    assign bus1.req_size     = req_size;
    assign bus1.req_unsigned = req_unsigned;
    assign bus1.req_addr     = req_addr;
    assign bus1.req_wdata    = req_wdata;

    byte_lane_data_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    byte_lane_data_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic        o_rdy [2];
    logic        o_vld [2];
    logic [31:0] o_rd  [2];
    logic        o_err [2];
    assign o_rdy[0] = bus0.req_ready;  assign o_rdy[1] = bus1.req_ready;
    assign o_vld[0] = bus0.rsp_valid;  assign o_vld[1] = bus1.rsp_valid;
    assign o_rd[0]  = bus0.rsp_rdata;  assign o_rd[1]  = bus1.rsp_rdata;
    assign o_err[0] = bus0.rsp_err;    assign o_err[1] = bus1.rsp_err;

    // Reference model state
    logic [7:0]  mdl [2][DEPTH];
    int          lat_of [2] = '{LAT0, LAT1};
    int          edge_cnt = 0;
    bit          pend [2] = '{1'b0, 1'b0};
    int          due [2];
    logic        m_w [2];
    logic [1:0]  m_sz [2];
    logic        m_u [2];
    logic [31:0] m_a [2];
    logic [31:0] m_wd [2];
    logic [31:0] exp_rd [2];
    logic        exp_err [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no DUT response within bound (t=%0t)", name, $time);
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
        if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
        return ({32'd0, a} + 64'(nbytes_of(sz))) > 64'(DEPTH);
    endfunction

    function automatic logic [31:0] model_load(input int s, input logic [1:0] sz, input logic u,
                                               input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nbytes_of(sz); i++) v = v | (32'(mdl[s][a + 32'(i)]) << (8 * i));
        if (sz == 2'b00 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 2'b01 && !u && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] model_word(input int s, input int a);
        return {mdl[s][a + 3], mdl[s][a + 2], mdl[s][a + 1], mdl[s][a]};
    endfunction

    // Model: a request accepted at edge e is answered from edge e+latency until the handshake edge.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            pend = '{1'b0, 1'b0};
`ifdef DMEM_CLEAR_ON_RESET_EN
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < DEPTH; i++) mdl[s][i] = 8'h00;
`endif
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (pend[s] && edge_cnt > due[s] && rsp_ready && sel == s) begin
                    pend[s] = 1'b0;
                end else if (!pend[s] && req_valid && sel == s) begin
                    pend[s] = 1'b1;
                    due[s]  = edge_cnt + lat_of[s];
                    m_w[s] = req_write; m_sz[s] = req_size; m_u[s] = req_unsigned;
                    m_a[s] = req_addr;  m_wd[s] = req_wdata;
                end
                if (pend[s] && edge_cnt == due[s]) begin
                    exp_err[s] = model_err(m_sz[s], m_a[s]);
                    exp_rd[s]  = '0;
                    if (!exp_err[s]) begin
                        if (m_w[s]) begin
                            for (int i = 0; i < nbytes_of(m_sz[s]); i++)
                                mdl[s][m_a[s] + 32'(i)] = m_wd[s][8*i +: 8];
                        end else begin
                            exp_rd[s] = model_load(s, m_sz[s], m_u[s], m_a[s]);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                bit ev;
                ev = pend[s] && (edge_cnt >= due[s]);
                chk($sformatf("req_ready[%0d]", s), {31'd0, o_rdy[s]}, {31'd0, !pend[s] && !rst});
                chk($sformatf("rsp_valid[%0d]", s), {31'd0, o_vld[s]}, {31'd0, ev});
                if (ev) begin
                    chk($sformatf("rsp_rdata[%0d]", s), o_rd[s], exp_rd[s]);
                    chk($sformatf("rsp_err[%0d]", s), {31'd0, o_err[s]}, {31'd0, exp_err[s]});
                end
            end
        end
    end

    task automatic txn(input int s, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic er, output int lat);
        bit acc;
        bit got;
        int acc_e;
        acc = 1'b0; got = 1'b0; rd = '0; er = 1'b0; lat = -1;
        sel = s; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = o_rdy[s];
            @(posedge clk); #1;
        end
        if (!acc) begin fail("accept timeout"); req_valid = 1'b0; return; end
        acc_e = edge_cnt;
        // Junk on the request side while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            if (o_vld[s]) begin
                got = 1'b1; rd = o_rd[s]; er = o_err[s]; lat = edge_cnt - acc_e;
            end
        end
        if (!got) begin fail("response timeout"); req_valid = 1'b0; return; end
        repeat (stall) @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic rst_in_access(input int s, input logic [31:0] a, input logic [31:0] wd);
        bit acc;
        acc = 1'b0;
        sel = s; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = o_rdy[s];
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!acc) begin fail("accept timeout (rst test)"); return; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (lat_of[s] + 2) begin
            @(negedge clk);
            chk("no rsp after rst", {31'd0, o_vld[s]}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] old_val;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset req_ready", {31'd0, o_rdy[s]}, 32'd0);
            chk("reset rsp_valid", {31'd0, o_vld[s]}, 32'd0);
            chk("reset rsp_rdata", o_rd[s], 32'd0);
            chk("reset rsp_err", {31'd0, o_err[s]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("ready after reset", {31'd0, o_rdy[0]}, 32'd1);
        @(posedge clk); #1;

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < DEPTH; a += 4) txn(s, 1'b1, 2'b10, 1'b0, 32'(a), $urandom, 0, rd, er, lat);

        // Directed word/byte/half accesses on the latency-1 instance
        txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        chk("sw err", {31'd0, er}, 32'd0);
        chk("sw latency", 32'(lat), 32'd1);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lw 0x10", rd, 32'hDEADBEEF);
        chk("lw latency", 32'(lat), 32'd1);
        txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd, er, lat);
        chk("lb 0x13", rd, 32'hFFFFFFDE);
        txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd, er, lat);
        chk("lbu 0x13", rd, 32'h000000DE);
        txn(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, rd, er, lat);
        chk("lh 0x12", rd, 32'hFFFFDEAD);
        txn(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAABBCC55, 0, rd, er, lat);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lw after sb", rd, 32'hDEAD55EF);
        chk("model word 0x10", model_word(0, 32'h10), 32'hDEAD55EF);

        // Error cases leave memory untouched
        txn(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0, rd, er, lat);
        chk("lw misaligned err", {31'd0, er}, 32'd1);
        chk("lw misaligned rdata", rd, 32'd0);
        txn(0, 1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF, 0, rd, er, lat);
        chk("sh misaligned err", {31'd0, er}, 32'd1);
        txn(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("size 11 err", {31'd0, er}, 32'd1);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, rd, er, lat);
        chk("lw out of range err", {31'd0, er}, 32'd1);
        chk("lw out of range rdata", rd, 32'd0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 0, rd, er, lat);
        chk("lw top word err", {31'd0, er}, 32'd0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("0x10 unchanged", rd, 32'hDEAD55EF);

        // Latency 4 with a stalled consumer
        txn(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 0, rd, er, lat);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, rd, er, lat);
        chk("lat4 lw", rd, 32'hCAFEF00D);
        chk("lat4 latency", 32'(lat), 32'd4);

        // Reset while a store is in flight
        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, 0, rd, er, lat);
            rst_in_access(s, 32'h20, 32'h12345678);
`ifdef DMEM_CLEAR_ON_RESET_EN
            old_val = 32'h0;
`else
            old_val = 32'h11111111;
`endif
            txn(s, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
            chk("lw after aborted sw", rd, old_val);
        end

        for (int i = 0; i < 500; i++) begin
            int          s;
            int          r;
            logic [1:0]  sz;
            logic [31:0] a;
            s  = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            if (r <= 6)      a = $urandom_range(0, DEPTH - 1) & ((sz == 2'b01) ? ~32'd1 : (sz == 2'b10) ? ~32'd3 : ~32'd0);
            else if (r == 7) a = $urandom_range(0, DEPTH - 1);
            else if (r == 8) a = 32'(DEPTH - 8 + $urandom_range(0, 7));
            else             a = $urandom;
            txn(s, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), rd, er, lat);
            chk("random latency", 32'(lat), 32'(lat_of[s]));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
